// File: rtl/counter_ext.sv
// Modulo-N up/down counter with synchronous load, prescaled enable, wrap or saturate
// at the range ends, terminal-count flag, one-cycle limit pulse and sticky overflow.
module counter_ext #(
    parameter int unsigned Size     = 5,
    parameter int unsigned Modulus  = 2 ** Size,
    parameter bit          Saturate = 1'b0,
    parameter int unsigned Prescale = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic            i_up,
    input  logic            i_load,
    input  logic [Size-1:0] i_load_value,
    input  logic            i_clear_overflow,
    output logic [Size-1:0] o_count,
    output logic            o_terminal,
    output logic            o_limit,
    output logic            o_overflow
);

    localparam int unsigned     TickW    = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [Size-1:0] MaxCount = Size'(Modulus - 1);
    localparam logic [TickW-1:0] LastTick = TickW'(Prescale - 1);

    logic [Size-1:0]  r_count;
    logic [TickW-1:0] r_tick;
    logic             r_limit;
    logic             r_overflow;

    logic [Size-1:0]  w_count_d;
    logic [TickW-1:0] w_tick_d;
    logic             w_limit_d;
    logic             w_overflow_d;
    logic             w_terminal;
    logic             w_tick_last;
    logic             w_step;
    logic             w_boundary;
    logic [Size-1:0]  w_load_clamped;
    logic [Size-1:0]  w_step_value;

    assign w_terminal     = i_up ? (r_count == MaxCount) : (r_count == '0);
    // With Prescale=1 the tick stays at zero, so every enabled cycle is a step.
    assign w_tick_last    = (r_tick == LastTick);
    assign w_step         = i_enable & w_tick_last;
    assign w_boundary     = ~i_load & w_step & w_terminal;
    assign w_load_clamped = (i_load_value > MaxCount) ? MaxCount : i_load_value;

    always_comb begin
        w_step_value = r_count;
        if (w_terminal) begin
            if (!Saturate) begin
                w_step_value = i_up ? '0 : MaxCount;
            end
        end else if (i_up) begin
            w_step_value = r_count + Size'(1);
        end else begin
            w_step_value = r_count - Size'(1);
        end
    end

    always_comb begin
        w_count_d = r_count;
        w_tick_d  = r_tick;
        if (i_load) begin
            w_count_d = w_load_clamped;
            w_tick_d  = '0;
        end else if (i_enable) begin
            if (w_tick_last) begin
                w_count_d = w_step_value;
                w_tick_d  = '0;
            end else begin
                w_tick_d  = r_tick + TickW'(1);
            end
        end
    end

    // A boundary step and a clear on the same edge leave the flag set.
    assign w_limit_d    = w_boundary;
    assign w_overflow_d = w_boundary | (r_overflow & ~i_clear_overflow);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count    <= '0;
            r_tick     <= '0;
            r_limit    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_d;
            r_tick     <= w_tick_d;
            r_limit    <= w_limit_d;
            r_overflow <= w_overflow_d;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = w_terminal;
    assign o_limit    = r_limit;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_counter_ext.sv
// Directed bench for counter_ext: wrap, saturate, prescaled and power-of-two instances
// share one stimulus stream; expected values are hand-computed per step.
module tb_counter_ext;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       up;
    logic       load;
    logic [4:0] load_value;
    logic       clear_ovf;

    logic [4:0] wr_count, sat_count, pre_count, p2_count;
    logic       wr_term, sat_term, pre_term, p2_term;
    logic       wr_limit, sat_limit, pre_limit, p2_limit;
    logic       wr_ovf, sat_ovf, pre_ovf, p2_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    counter_ext #(.Size(5), .Modulus(20), .Saturate(1'b0), .Prescale(1)) u_wrap (
        .i_clock(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_load(load),
        .i_load_value(load_value), .i_clear_overflow(clear_ovf), .o_count(wr_count),
        .o_terminal(wr_term), .o_limit(wr_limit), .o_overflow(wr_ovf)
    );

    counter_ext #(.Size(5), .Modulus(20), .Saturate(1'b1), .Prescale(1)) u_sat (
        .i_clock(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_load(load),
        .i_load_value(load_value), .i_clear_overflow(clear_ovf), .o_count(sat_count),
        .o_terminal(sat_term), .o_limit(sat_limit), .o_overflow(sat_ovf)
    );

    counter_ext #(.Size(5), .Modulus(20), .Saturate(1'b0), .Prescale(3)) u_pre (
        .i_clock(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_load(load),
        .i_load_value(load_value), .i_clear_overflow(clear_ovf), .o_count(pre_count),
        .o_terminal(pre_term), .o_limit(pre_limit), .o_overflow(pre_ovf)
    );

    counter_ext #(.Size(5), .Modulus(32), .Saturate(1'b0), .Prescale(1)) u_pow2 (
        .i_clock(clk), .i_reset(reset), .i_enable(enable), .i_up(up), .i_load(load),
        .i_load_value(load_value), .i_clear_overflow(clear_ovf), .o_count(p2_count),
        .o_terminal(p2_term), .o_limit(p2_limit), .o_overflow(p2_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0;
        load_value = '0; clear_ovf = 1'b0;

        // 1: reset, then count up for 33 cycles across all instances
        cyc(); cyc();
        check("rst_count", 32'(wr_count), 0);
        check("rst_limit", 32'(wr_limit), 0);
        check("rst_ovf", 32'(wr_ovf), 0);
        check("rst_pre_count", 32'(pre_count), 0);
        reset = 1'b0; enable = 1'b1; up = 1'b1;
        #1;
        check("t1_term0", 32'(wr_term), 0);
        for (int k = 1; k <= 33; k++) begin
            cyc();
            check("t1_wr_count", 32'(wr_count), 32'(k % 20));
            check("t1_wr_limit", 32'(wr_limit), 32'(k == 20));
            check("t1_wr_ovf", 32'(wr_ovf), 32'(k >= 20));
            check("t1_wr_term", 32'(wr_term), 32'((k % 20) == 19));
            check("t1_p2_count", 32'(p2_count), 32'(k % 32));
            check("t1_p2_limit", 32'(p2_limit), 32'(k == 32));
            check("t1_p2_ovf", 32'(p2_ovf), 32'(k >= 32));
            check("t1_sat_count", 32'(sat_count), (k < 19) ? 32'(k) : 32'd19);
            check("t1_sat_limit", 32'(sat_limit), 32'(k >= 20));
            check("t1_pre_count", 32'(pre_count), 32'(k / 3));
        end

        // 2: clamped load, down steps, down-wrap from 0
        load = 1'b1; load_value = 5'd31; enable = 1'b0;
        cyc();
        check("t2_load_clamp", 32'(wr_count), 19);
        check("t2_load_p2", 32'(p2_count), 31);
        check("t2_load_sat_limit", 32'(sat_limit), 0);
        check("t2_load_sat_ovf", 32'(sat_ovf), 1);
        load = 1'b0; enable = 1'b1; up = 1'b0;
        cyc();
        check("t2_down1", 32'(wr_count), 18);
        cyc();
        check("t2_down2", 32'(wr_count), 17);
        check("t2_term_mid", 32'(wr_term), 0);
        load = 1'b1; load_value = 5'd0; enable = 1'b0;
        cyc();
        check("t2_load0", 32'(wr_count), 0);
        check("t2_term_down0", 32'(wr_term), 1);
        load = 1'b0; enable = 1'b1;
        cyc();
        check("t2_wrap_down", 32'(wr_count), 19);
        check("t2_wrap_limit", 32'(wr_limit), 1);

        // 3: saturate mode holds at both ends
        reset = 1'b1; load = 1'b0; enable = 1'b0;
        cyc();
        reset = 1'b0; load = 1'b1; load_value = 5'd19; up = 1'b1; enable = 1'b1;
        cyc();
        check("t3_load19", 32'(sat_count), 19);
        check("t3_load_limit", 32'(sat_limit), 0);
        check("t3_load_ovf", 32'(sat_ovf), 0);
        load = 1'b0;
        cyc();
        check("t3_hold_top", 32'(sat_count), 19);
        check("t3_top_limit", 32'(sat_limit), 1);
        check("t3_top_ovf", 32'(sat_ovf), 1);
        load = 1'b1; load_value = 5'd0; enable = 1'b0;
        cyc();
        check("t3_load0", 32'(sat_count), 0);
        check("t3_load0_limit", 32'(sat_limit), 0);
        load = 1'b0; up = 1'b0; enable = 1'b1;
        cyc();
        check("t3_hold_bot", 32'(sat_count), 0);
        check("t3_bot_limit", 32'(sat_limit), 1);
        up = 1'b1;
        cyc();
        check("t3_up_from0", 32'(sat_count), 1);
        check("t3_up_limit", 32'(sat_limit), 0);

        // 4: prescale by 3, then a two-cycle enable gap mid-interval
        reset = 1'b1; enable = 1'b0;
        cyc();
        reset = 1'b0; enable = 1'b1; up = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check("t4_pre_count", 32'(pre_count), 32'(k / 3));
        end
        cyc();
        check("t4_gap_a", 32'(pre_count), 3);
        enable = 1'b0;
        cyc();
        check("t4_gap_b", 32'(pre_count), 3);
        cyc();
        check("t4_gap_c", 32'(pre_count), 3);
        enable = 1'b1;
        cyc();
        check("t4_gap_d", 32'(pre_count), 3);
        cyc();
        check("t4_gap_step", 32'(pre_count), 4);
        check("t4_pre_limit", 32'(pre_limit), 0);

        // 5: set beats clear on the same edge; clear alone next cycle
        reset = 1'b1; enable = 1'b0;
        cyc();
        reset = 1'b0; load = 1'b1; load_value = 5'd0;
        cyc();
        load = 1'b0; enable = 1'b1; up = 1'b0;
        cyc();
        check("t5_setup_count", 32'(wr_count), 19);
        check("t5_setup_ovf", 32'(wr_ovf), 1);
        up = 1'b1; clear_ovf = 1'b1;
        cyc();
        check("t5_wrap_count", 32'(wr_count), 0);
        check("t5_set_wins", 32'(wr_ovf), 1);
        check("t5_wrap_limit", 32'(wr_limit), 1);
        enable = 1'b0;
        cyc();
        check("t5_cleared", 32'(wr_ovf), 0);
        check("t5_limit_drop", 32'(wr_limit), 0);
        clear_ovf = 1'b0;

        // 6: reset beats load and enable, and drops a partial prescale tick
        load = 1'b1; load_value = 5'd0; enable = 1'b0;
        cyc();
        load = 1'b0; enable = 1'b1; up = 1'b0;
        cyc();
        check("t6_pre_ovf", 32'(wr_ovf), 1);
        load = 1'b1; load_value = 5'd7; enable = 1'b0;
        cyc();
        check("t6_load7", 32'(pre_count), 7);
        load = 1'b0; enable = 1'b1; up = 1'b1;
        cyc();
        check("t6_wr_count8", 32'(wr_count), 8);
        reset = 1'b1; load = 1'b1; load_value = 5'd7; enable = 1'b1;
        cyc();
        check("t6_rst_count", 32'(wr_count), 0);
        check("t6_rst_limit", 32'(wr_limit), 0);
        check("t6_rst_ovf", 32'(wr_ovf), 0);
        check("t6_rst_pre", 32'(pre_count), 0);
        reset = 1'b0; load = 1'b0; enable = 1'b1; up = 1'b1;
        cyc();
        check("t6_tick_a", 32'(pre_count), 0);
        cyc();
        check("t6_tick_b", 32'(pre_count), 0);
        cyc();
        check("t6_tick_step", 32'(pre_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
